fp_mult_pipe: RTL
=================

# fp_mult_pipe

Parametrised, pipelined IEEE-754 binary floating-point multiplier with valid/ready handshakes and per-result exception flags. It is the next generation of the single-precision multiplier in the arithmetic datapath. It supports any exponent/fraction width, round-to-nearest-even, NaN/Inf classification and backpressure, at one result per cycle with fixed latency.

## Interface
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored fraction width. Word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept the pair this cycle.
- a, b  in  W each  operands, {sign, exp, frac}.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  W  product.
- flags  out  4  {invalid, overflow, underflow, inexact}, aligned with result.

## Operation
- Unpack: exp==0 means zero (subnormal inputs are flushed to signed zero, not flagged). exp==all-ones with frac==0 means Inf; with frac!=0 it is NaN.
- sign = sa^sb for all non-NaN results.
- Special cases, highest priority first:
  - Any NaN, or Inf×0: canonical qNaN {0, all-ones, 1 followed by zeros}, invalid=1.
  - Inf×nonzero: signed Inf.
  - Zero×finite: signed zero.
  - Special-case results carry no other flags.
- Normal path:
  - (MAN_W+1)×(MAN_W+1) unsigned product P, 2·MAN_W+2 bits.
  - norm = P[MSB]. Shift left 1 if norm=0.
  - E = ea+eb−BIAS+norm, signed, EXP_W+2 bits. BIAS = 2^(EXP_W−1)−1.
- Rounding is round-to-nearest-even.
  - lsb = last kept bit, guard = next bit, sticky = OR of the rest.
  - Increment when guard & (sticky | lsb).
  - inexact = guard | sticky.
  - A rounding carry out of the fraction sets frac=0 and E+=1.
- After rounding:
  - E ≥ 2^EXP_W−1: signed Inf, overflow=1, inexact=1.
  - E ≤ 0: signed zero (flush-to-zero), underflow=1, inexact=1.
  - Otherwise pack {sign, E[EXP_W−1:0], frac}.
- An input is accepted when in_valid & in_ready.
- A result is retired when out_valid & out_ready.

## Timing
- 3-stage pipeline:
  - S1: unpack, classify, exponent sum.
  - S2: mantissa product.
  - S3: normalise, round, pack into the output register.
- Latency: a pair accepted at edge n produces out_valid at edge n+3 if there is no stall.
- Throughput: 1 per cycle.
- Stall rule: stall = out_valid & ~out_ready. in_ready = ~stall. All stages hold while stalled, and no bubble is inserted on release.
- Valid bits propagate with the data. Empty stages do not block the pipeline; in_ready stays 1 while out_valid=0.
- Held output: result and flags remain stable while out_valid=1 and out_ready=0.
- Reset (async assert, deassert sampled on clk):
  - out_valid=0, result=0, flags=0, all stage valids=0.
  - Any in-flight operations are discarded and are not replayed.
  - in_ready=1 from the first cycle after reset.

## Structure
- Package fp_mult_pkg holds:
  - the class enum {ZERO, NORM, INF, NAN};
  - the flag-index constants;
  - a bias function of EXP_W;
  - a canonical-qNaN constant function.
- Sub-module mant_mult_pipe: a parametrised registered (MAN_W+1)-bit unsigned multiplier forming S2, with an enable input for stall.

## Test plan
- 0x40000000 × 0x40400000 (2.0×3.0), 32-bit -> 0x40C00000, flags 0000, out_valid exactly 3 cycles after accept.
- 0x3F800001 × 0x3FC00000 (exact tie, lsb=1) -> 0x3FC00002, inexact=1.
- 0x7F800000 × 0x00000000 -> 0x7FC00000, invalid=1. Repeat with operand 0x7FC00001 -> 0x7FC00000, invalid=1.
- 0x7F7FFFFF × 0x40000000 -> 0x7F800000, overflow=1, inexact=1.
- 0x00800000 × 0x3F000000 -> 0x00000000, underflow=1, inexact=1.
- Backpressure: stream 8 back-to-back pairs with out_ready low for cycles 4–6.
  - Required: in_ready=0 exactly during the stall.
  - Required: results are in order with no loss or duplication, and result holds stable during the stall.
- Reset mid-stream: assert rst_n=0 with 3 operations in flight.
  - Required: out_valid=0 immediately.
  - Required: after release, no stale results appear, and the next accepted pair completes with latency 3.

Source files
------------

// File: rtl/fp_mult_pkg.sv
// Shared types and helpers for the pipelined IEEE-754 multiplier.
// Operand classes, flag bit positions, bias and canonical quiet-NaN builders.
package fp_mult_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } fp_class_e;

  localparam int FLG_INEXACT   = 0;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_INVALID   = 3;
  localparam int FLG_W         = 4;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Wide enough for any practical format; callers slice off the low W bits.
  function automatic logic [127:0] fp_qnan(input int exp_w, input int man_w);
    logic [127:0] r;
    r = (((128'd1 << exp_w) - 128'd1) << man_w) | (128'd1 << (man_w - 1));
    return r;
  endfunction

endpackage

// File: rtl/fp_mult_pipe_if.sv
// Operand/result handshake bundle for fp_mult_pipe.
// master = producer/consumer side, slave = the multiplier.
interface fp_mult_pipe_if
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     result;
  logic [FLG_W-1:0] flags;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, flags
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, flags
  );

endinterface

// File: rtl/mant_mult_pipe.sv
// Registered unsigned N x N multiplier forming the product stage; 1 cycle.
// The register holds its value while i_en is low so a stall freezes it.
module mant_mult_pipe #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_en,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic [2*N-1:0] o_p
);

  logic [2*N-1:0] r_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= (2*N)'(i_a) * (2*N)'(i_b);
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined IEEE-754 multiplier, RNE, FTZ; out_valid 3 cycles after accept, 1/cycle.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready.
module fp_mult_pipe
  import fp_mult_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic         clk,
  input  logic         rst_n,
  fp_mult_pipe_if.slave bus
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int EW   = EXP_W + 2;
  localparam int MW   = MAN_W + 1;
  localparam int PW   = 2 * MW;
  localparam int BIAS = fp_bias(EXP_W);
  localparam logic [127:0]  QNAN_WIDE = fp_qnan(EXP_W, MAN_W);
  localparam logic [W-1:0]  QNAN      = QNAN_WIDE[W-1:0];
  localparam logic [EW-1:0] EMAX      = EW'((1 << EXP_W) - 1);
  localparam logic [EW-1:0] EBIAS     = EW'(BIAS);

  function automatic fp_class_e classify(input logic [EXP_W-1:0] e,
                                         input logic [MAN_W-1:0] f);
    if (e == '0) return ZERO;
    if (&e)      return (f != '0) ? NAN : INF;
    return NORM;
  endfunction

  logic r_out_vld;
  logic w_adv;

  assign w_adv        = ~(r_out_vld & ~bus.out_ready);
  assign bus.in_ready = w_adv;

  // Operand capture on accept.
  logic         r_in_vld;
  logic [W-1:0] r_in_a;
  logic [W-1:0] r_in_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_vld <= 1'b0;
      r_in_a   <= '0;
      r_in_b   <= '0;
    end else if (w_adv) begin
      r_in_vld <= bus.in_valid;
      r_in_a   <= bus.a;
      r_in_b   <= bus.b;
    end
  end

  // S1: unpack, classify, exponent sum.
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  fp_class_e        w_ca, w_cb, w_cls;
  logic [EW-1:0]    w_esum;
  logic [MW-1:0]    w_ma, w_mb;

  assign w_ea = r_in_a[W-2:MAN_W];
  assign w_eb = r_in_b[W-2:MAN_W];
  assign w_fa = r_in_a[MAN_W-1:0];
  assign w_fb = r_in_b[MAN_W-1:0];

  always_comb begin
    w_ca  = classify(w_ea, w_fa);
    w_cb  = classify(w_eb, w_fb);
    w_cls = NORM;
    if (w_ca == NAN || w_cb == NAN ||
        (w_ca == INF && w_cb == ZERO) || (w_ca == ZERO && w_cb == INF)) begin
      w_cls = NAN;
    end else if (w_ca == INF || w_cb == INF) begin
      w_cls = INF;
    end else if (w_ca == ZERO || w_cb == ZERO) begin
      w_cls = ZERO;
    end
    w_esum = EW'(w_ea) + EW'(w_eb) - EBIAS;
    w_ma   = (w_ca == NORM) ? {1'b1, w_fa} : '0;
    w_mb   = (w_cb == NORM) ? {1'b1, w_fb} : '0;
  end

  logic          r_s1_vld;
  logic          r_s1_sign;
  fp_class_e     r_s1_cls;
  logic [EW-1:0] r_s1_exp;
  logic [MW-1:0] r_s1_ma;
  logic [MW-1:0] r_s1_mb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld  <= 1'b0;
      r_s1_sign <= 1'b0;
      r_s1_cls  <= ZERO;
      r_s1_exp  <= '0;
      r_s1_ma   <= '0;
      r_s1_mb   <= '0;
    end else if (w_adv) begin
      r_s1_vld  <= r_in_vld;
      r_s1_sign <= r_in_a[W-1] ^ r_in_b[W-1];
      r_s1_cls  <= w_cls;
      r_s1_exp  <= w_esum;
      r_s1_ma   <= w_ma;
      r_s1_mb   <= w_mb;
    end
  end

  // S2: mantissa product, sideband travels alongside.
  logic [PW-1:0] w_prod;
  logic          r_s2_vld;
  logic          r_s2_sign;
  fp_class_e     r_s2_cls;
  logic [EW-1:0] r_s2_exp;

  mant_mult_pipe #(.N(MW)) u_mant (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_adv),
    .i_a   (r_s1_ma),
    .i_b   (r_s1_mb),
    .o_p   (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_vld  <= 1'b0;
      r_s2_sign <= 1'b0;
      r_s2_cls  <= ZERO;
      r_s2_exp  <= '0;
    end else if (w_adv) begin
      r_s2_vld  <= r_s1_vld;
      r_s2_sign <= r_s1_sign;
      r_s2_cls  <= r_s1_cls;
      r_s2_exp  <= r_s1_exp;
    end
  end

  // S3: normalise so the leading one sits just above w_pn, then round to nearest even.
  logic             w_norm;
  logic [PW-2:0]    w_pn;
  logic [MAN_W-1:0] w_frac;
  logic             w_lsb, w_guard, w_sticky;
  logic [MW-1:0]    w_rnd;
  logic [EW-1:0]    w_efin;
  logic [W-1:0]     w_res;
  logic [FLG_W-1:0] w_flg;

  always_comb begin
    w_norm   = w_prod[PW-1];
    w_pn     = w_norm ? w_prod[PW-2:0] : {w_prod[PW-3:0], 1'b0};
    w_frac   = w_pn[PW-2:MW];
    w_lsb    = w_pn[MW];
    w_guard  = w_pn[MAN_W];
    w_sticky = |w_pn[MAN_W-1:0];
    w_rnd    = {1'b0, w_frac} + MW'(w_guard & (w_sticky | w_lsb));
    w_efin   = r_s2_exp + EW'(w_norm) + EW'(w_rnd[MAN_W]);
    w_res    = '0;
    w_flg    = '0;
    case (r_s2_cls)
      NAN: begin
        w_res              = QNAN;
        w_flg[FLG_INVALID] = 1'b1;
      end
      INF:  w_res = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ZERO: w_res = {r_s2_sign, {(W-1){1'b0}}};
      default: begin
        if ($signed(w_efin) >= $signed(EMAX)) begin
          w_res               = {r_s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          w_flg[FLG_OVERFLOW] = 1'b1;
          w_flg[FLG_INEXACT]  = 1'b1;
        end else if (w_efin[EW-1] || w_efin == '0) begin
          w_res                = {r_s2_sign, {(W-1){1'b0}}};
          w_flg[FLG_UNDERFLOW] = 1'b1;
          w_flg[FLG_INEXACT]   = 1'b1;
        end else begin
          w_res              = {r_s2_sign, w_efin[EXP_W-1:0], w_rnd[MAN_W-1:0]};
          w_flg[FLG_INEXACT] = w_guard | w_sticky;
        end
      end
    endcase
  end

  logic [W-1:0]     r_result;
  logic [FLG_W-1:0] r_flags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_vld <= 1'b0;
      r_result  <= '0;
      r_flags   <= '0;
    end else if (w_adv) begin
      r_out_vld <= r_s2_vld;
      if (r_s2_vld) begin
        r_result <= w_res;
        r_flags  <= w_flg;
      end
    end
  end

  assign bus.out_valid = r_out_vld;
  assign bus.result    = r_result;
  assign bus.flags     = r_flags;

endmodule
